// File: rtl/timer_counter.sv
// Bus-mapped down-counter timer with one-shot and auto-reload modes.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT; irq = IM & sticky IRQ flag.
module timer_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic        wr_any;
   logic        wr_ctrl;
   logic        wr_preset;

   logic        load_count;
   logic        dec_count;
   logic        zero_count;
   logic        set_flag;
   logic        clr_flag_fsm;
   logic        clr_en;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   assign wr_any    = we && (byteen != '0);
   assign wr_ctrl   = wr_any && (addr == 2'd0);
   assign wr_preset = wr_any && (addr == 2'd1);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state   = state;
      load_count   = 1'b0;
      dec_count    = 1'b0;
      zero_count   = 1'b0;
      set_flag     = 1'b0;
      clr_flag_fsm = 1'b0;
      clr_en       = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_en) next_state = LOAD;
         end
         LOAD: begin
            load_count = 1'b1;
            next_state = CNT;
         end
         CNT: begin
            if (!ctrl_en) begin
               next_state = IDLE;
            end else if (count > 32'd1) begin
               dec_count = 1'b1;
            end else begin
               zero_count = 1'b1;
               set_flag   = 1'b1;
               next_state = INT;
            end
         end
         INT: begin
            if (!ctrl_en) begin
               next_state = IDLE;
            end else if (ctrl_mode == 2'b01) begin
               clr_flag_fsm = 1'b1;
               next_state   = LOAD;
            end else begin
               clr_en     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 2'b00;
         ctrl_im   <= 1'b0;
         preset    <= '0;
         count     <= '0;
         irq_flag  <= 1'b0;
      end else begin
         if (load_count)      count <= preset;
         else if (dec_count)  count <= count - 32'd1;
         else if (zero_count) count <= '0;

         // The bus write is placed after the FSM clear so written lanes win.
         if (clr_en) ctrl_en <= 1'b0;
         if (wr_ctrl && byteen[0]) begin
            ctrl_en   <= wdata[0];
            ctrl_mode <= wdata[2:1];
            ctrl_im   <= wdata[3];
         end

         if (wr_preset) preset <= merge_bytes(preset, wdata, byteen);

         if (set_flag)
            irq_flag <= 1'b1;
         else if (wr_ctrl || wr_preset || clr_flag_fsm)
            irq_flag <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         2'd0:    rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
         2'd1:    rdata = preset;
         2'd2:    rdata = count;
         default: rdata = '0;
      endcase
   end

   assign irq = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Testbench for timer_counter: register-access vector table followed by
// cycle-exact sequences for one-shot, auto-reload, freeze and reset cases.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   typedef struct {
      logic        rst;
      logic [1:0]  addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        irq;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   timer_counter dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .we     (we),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus, queue its expectation, check after the edge.
   task automatic apply(input vec_t v, input string name);
      exp_t e;
      reset  = v.rst;
      addr   = v.addr;
      we     = v.we;
      byteen = v.be;
      wdata  = v.wdata;
      sb.push_back('{rdata: v.exp_rdata, irq: v.exp_irq, name: name});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (rdata !== e.rdata || irq !== e.irq) begin
         n_err++;
         $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                  e.name, rdata, irq, e.rdata, e.irq);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d,
                     input logic [31:0] er, input logic ei, input string nm);
      vec_t v;
      v = '{1'b1, a, 1'b1, be, d, er, ei};
      apply(v, nm);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] er, input logic ei,
                     input string nm);
      vec_t v;
      v = '{1'b1, a, 1'b0, 4'h0, 32'h0, er, ei};
      apply(v, nm);
   endtask

   vec_t tbl[13];

   initial begin
      reset  = 1'b0;
      addr   = 2'd0;
      we     = 1'b0;
      byteen = 4'h0;
      wdata  = 32'h0;

      //          rst   addr  we    be     wdata          exp_rdata      irq
      tbl[0]  = '{1'b0, 2'd1, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b0, 2'd0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[2]  = '{1'b1, 2'd1, 1'b1, 4'h2, 32'h0000_0100, 32'h0000_0100, 1'b0};
      tbl[3]  = '{1'b1, 2'd1, 1'b1, 4'h1, 32'h0000_00AB, 32'h0000_01AB, 1'b0};
      tbl[4]  = '{1'b1, 2'd1, 1'b1, 4'hC, 32'h1234_5678, 32'h1234_01AB, 1'b0};
      tbl[5]  = '{1'b1, 2'd1, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h1234_01AB, 1'b0};
      tbl[6]  = '{1'b1, 2'd3, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      tbl[7]  = '{1'b1, 2'd2, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      tbl[8]  = '{1'b1, 2'd0, 1'b1, 4'hF, 32'hFFFF_FFF4, 32'h0000_0004, 1'b0};
      tbl[9]  = '{1'b1, 2'd0, 1'b1, 4'hE, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0};
      tbl[10] = '{1'b1, 2'd0, 1'b1, 4'h1, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[11] = '{1'b1, 2'd1, 1'b0, 4'h0, 32'h0000_0000, 32'h1234_01AB, 1'b0};
      tbl[12] = '{1'b1, 2'd2, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};

      for (int unsigned i = 0; i < 13; i++)
         apply(tbl[i], $sformatf("tbl%0d", i));

      // One-shot, PRESET=5, IM=1
      wr(2'd1, 4'hF, 32'd5, 32'd5, 1'b0, "os_preset");
      wr(2'd0, 4'h1, 32'h9, 32'h9, 1'b0, "os_start");
      for (int unsigned k = 1; k <= 7; k++) begin
         logic [31:0] ec;
         ec = (k >= 2 && k <= 6) ? 32'(7 - k) : 32'd0;
         rd(2'd2, ec, (k == 7), $sformatf("os_count_t%0d", k));
      end
      rd(2'd0, 32'h8, 1'b1, "os_en_cleared");
      rd(2'd0, 32'h8, 1'b1, "os_irq_held");
      wr(2'd0, 4'h1, 32'h8, 32'h8, 1'b0, "os_ctrl_wr_clears");
      rd(2'd0, 32'h8, 1'b0, "os_irq_stays_low");

      // Auto-reload, PRESET=3, period 5
      wr(2'd1, 4'hF, 32'd3, 32'd3, 1'b0, "ar_preset");
      wr(2'd0, 4'h1, 32'hB, 32'hB, 1'b0, "ar_start");
      for (int unsigned k = 1; k <= 13; k++) begin
         logic [31:0] ec;
         logic        ei;
         ec = 32'd0;
         ei = 1'b0;
         if (k >= 2) begin
            case ((k - 2) % 5)
               0: ec = 32'd3;
               1: ec = 32'd2;
               2: ec = 32'd1;
               3: ei = 1'b1;
               default: ;
            endcase
         end
         rd(2'd2, ec, ei, $sformatf("ar_t%0d", k));
      end
      // COUNT is 2 here; reset mid-count
      begin
         vec_t v;
         v = '{1'b0, 2'd2, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
         apply(v, "ar_reset");
      end
      rd(2'd0, 32'h0, 1'b0, "ar_reset_ctrl");
      rd(2'd1, 32'h0, 1'b0, "ar_reset_preset");
      for (int unsigned k = 0; k < 20; k++)
         rd(2'd2, 32'h0, 1'b0, $sformatf("ar_quiet%0d", k));

      // One-shot with IM=0, later enable mask with a CTRL write
      wr(2'd1, 4'hF, 32'd2, 32'd2, 1'b0, "m_preset");
      wr(2'd0, 4'h1, 32'h1, 32'h1, 1'b0, "m_start");
      rd(2'd2, 32'd0, 1'b0, "m_t1");
      rd(2'd2, 32'd2, 1'b0, "m_t2");
      rd(2'd2, 32'd1, 1'b0, "m_t3");
      rd(2'd2, 32'd0, 1'b0, "m_t4_masked");
      rd(2'd0, 32'h0, 1'b0, "m_en_cleared");
      wr(2'd0, 4'h1, 32'h8, 32'h8, 1'b0, "m_im_write");
      rd(2'd0, 32'h8, 1'b0, "m_flag_gone");

      // Freeze and restart, PRESET changes apply at next LOAD
      wr(2'd1, 4'hF, 32'h40, 32'h40, 1'b0, "f_preset");
      wr(2'd0, 4'h1, 32'h1, 32'h1, 1'b0, "f_start");
      rd(2'd2, 32'h00, 1'b0, "f_t1");
      rd(2'd2, 32'h40, 1'b0, "f_t2");
      rd(2'd2, 32'h3F, 1'b0, "f_t3");
      rd(2'd2, 32'h3E, 1'b0, "f_t4");
      wr(2'd0, 4'h1, 32'h0, 32'h0, 1'b0, "f_disable");
      rd(2'd2, 32'h3D, 1'b0, "f_frozen1");
      rd(2'd2, 32'h3D, 1'b0, "f_frozen2");
      rd(2'd2, 32'h3D, 1'b0, "f_frozen3");
      wr(2'd1, 4'hF, 32'h10, 32'h10, 1'b0, "f_new_preset");
      wr(2'd0, 4'h1, 32'h1, 32'h1, 1'b0, "f_restart");
      rd(2'd2, 32'h3D, 1'b0, "f_r1");
      rd(2'd2, 32'h10, 1'b0, "f_r2_loaded");
      rd(2'd2, 32'h0F, 1'b0, "f_r3");
      wr(2'd1, 4'hF, 32'h20, 32'h20, 1'b0, "f_preset_in_cnt");
      rd(2'd2, 32'h0D, 1'b0, "f_count_unaffected");
      wr(2'd0, 4'h1, 32'h0, 32'h0, 1'b0, "f_stop");
      wr(2'd1, 4'hF, 32'h0, 32'h0, 1'b0, "z_preset0");

      // PRESET=0 behaves like 1; CTRL write vs FSM EN-clear; flag set wins
      wr(2'd0, 4'h1, 32'h9, 32'h9, 1'b0, "z_start");
      rd(2'd2, 32'h0C, 1'b0, "z_t1_held");
      rd(2'd2, 32'h00, 1'b0, "z_t2_load");
      rd(2'd2, 32'h00, 1'b1, "z_t3_int");
      wr(2'd0, 4'h1, 32'h9, 32'h9, 1'b0, "z_wr_beats_en_clear");
      rd(2'd2, 32'h00, 1'b0, "z_re_t1");
      rd(2'd2, 32'h00, 1'b0, "z_re_t2");
      wr(2'd0, 4'h1, 32'h9, 32'h9, 1'b1, "z_set_beats_clear");
      rd(2'd0, 32'h8, 1'b1, "z_en_cleared");
      wr(2'd0, 4'h1, 32'h0, 32'h0, 1'b0, "z_final_clear");

      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port addr, input, 2 bits: word offset from the bridge; 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-004 SHALL have port we, input, 1 bit: write strobe from the bridge, already qualified by chip-select.
REQ-005 SHALL have port byteen, input, 4 bits: byte-lane write enables; bit i gates wdata[8i+7:8i].
REQ-006 SHALL have port wdata, input, 32 bits: store data.
REQ-007 SHALL have port rdata, output, 32 bits: combinational read of the register selected by addr.
REQ-008 SHALL have port irq, output, 1 bit: interrupt request to the CPU HWInt input.

Function
REQ-009 CTRL fields SHALL be: bit0 EN (enable), bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask); bits31:4 SHALL be read-only zero.
REQ-010 PRESET SHALL be a 32-bit read/write register; COUNT SHALL be 32-bit read-only, and bus writes to it SHALL be ignored.
REQ-011 Writes SHALL update only the byte lanes with byteen set; we=1 with byteen=0000, or addr=3, SHALL change nothing.
REQ-012 rdata SHALL return CTRL (zero-extended), PRESET or COUNT for addr 0/1/2, and 0 for addr 3.
REQ-013 FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-014 IDLE: if EN=1, next state SHALL be LOAD; otherwise stay in IDLE with COUNT held.
REQ-015 LOAD: COUNT SHALL be loaded with PRESET, and next state SHALL be CNT.
REQ-016 CNT, EN=0: next state SHALL be IDLE with COUNT held.
REQ-017 CNT, EN=1, COUNT>1: COUNT SHALL decrement by 1.
REQ-018 CNT, EN=1, COUNT<=1: COUNT SHALL be set to 0, the IRQ flag SHALL be set, and next state SHALL be INT.
REQ-019 INT, one-shot: EN SHALL be cleared, next state SHALL be IDLE, and the IRQ flag SHALL stay set.
REQ-020 INT, auto-reload: next state SHALL be LOAD, and the IRQ flag SHALL be cleared on that edge, giving a one-cycle flag.
REQ-021 In INT, EN=0 (cleared by software) SHALL send the FSM to IDLE regardless of MODE.
REQ-022 irq SHALL equal IM AND the IRQ flag, driven from registers with no combinational path from bus inputs.
REQ-023 Any bus write to CTRL or PRESET SHALL clear the IRQ flag, unless the flag is being set on the same edge; setting wins, so no interrupt is lost.
REQ-024 A bus write to CTRL on the same edge the FSM clears EN (REQ-019) SHALL take precedence for the written byte lanes.
REQ-025 A PRESET write during CNT SHALL NOT affect the running COUNT; it SHALL take effect at the next LOAD.
REQ-026 Latency: with PRESET=N>=1, an edge that sets EN=1 from IDLE SHALL make the IRQ flag set N+2 edges later.
REQ-027 Auto-reload period SHALL be N+2 cycles.
REQ-028 PRESET=0 SHALL behave like PRESET=1: INT is reached on the edge after LOAD.
REQ-029 COUNT SHALL never wrap below 0.

Reset
REQ-030 reset=0 at a clock edge SHALL force CTRL=0, PRESET=0, COUNT=0, IRQ flag=0 and state IDLE; irq=0 and rdata reflects the zeroed registers.
REQ-031 Reset asserted mid-count or in INT SHALL abort the operation, with no irq pulse after release.
REQ-032 Reset SHALL take priority over a simultaneous bus write.

Verification
REQ-033 Scenario: PRESET=5, then CTRL=0x9 written at edge t0 -> COUNT reads 5,4,3,2,1 at t2..t6; COUNT=0 and irq=1 from t7; CTRL reads 0x8 after t8; irq stays 1 until a CTRL write.
REQ-034 Scenario: PRESET=3, CTRL=0xB (auto-reload, IM=1) -> irq is a one-cycle pulse every 5 cycles, with COUNT reloaded to 3 two edges after each pulse.
REQ-035 Scenario: CTRL=0x1 (IM=0), one-shot expires -> irq stays 0 while the flag is set; a later write CTRL=0x8 (IM=1, EN=0) on its own edge clears the flag and irq remains 0.
REQ-036 Scenario: PRESET write of 0x100 with byteen=0010 onto PRESET=0 -> PRESET=0x00000100; write to addr 2 with 0xFFFFFFFF -> COUNT unchanged; a read of addr 3 returns 0.
REQ-037 Scenario: counting with COUNT=0x40, CTRL write EN=0 -> COUNT freezes at its current value; EN=1 re-enabled -> LOAD restarts from PRESET.
REQ-038 Scenario: reset=0 for one edge while COUNT=2 in auto-reload -> all registers 0, state IDLE, and no irq for 20 cycles afterwards.
